mips_fetch_controller: RTL and testbench

Instruction fetch sequencer for the mini MIPS core. It owns the program counter and drives the word address of the combinational 16-bit instruction memory. Fetched words are buffered in a small queue and handed to decode over a valid/ready handshake. Branch and jump redirects flush the queue and retarget the PC.

---
 rtl/mips_fetch_controller.sv | 133 +++++++++++++
 tb/tb_mips_fetch_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives imem word address, queues fetched words for decode.
// Latency: word at pc pushed at end of cycle N is presented on inst/inst_pc in cycle N+1; redirect costs one bubble.
// Backpressure: inst_valid/inst_ready handshake; a full queue with no pop stalls the PC. Optional halt: MIPS_FETCH_HALT_EN.
module mips_fetch_controller #(
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int unsigned MEM_WORDS = 16,
    parameter int unsigned DEPTH     = 2
`ifdef MIPS_FETCH_HALT_EN
    ,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF
`endif
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_instruction,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        halted
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0] PC_LAST = 32'(MEM_WORDS - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] word;
    } fetch_entry_t;

`ifdef MIPS_FETCH_HALT_EN
    typedef enum logic {ST_FETCH = 1'b0, ST_HALT = 1'b1} state_t;
`else
    typedef enum logic {ST_FETCH = 1'b0} state_t;
`endif

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    pc_q;
    logic [31:0]    pc_d;
    fetch_entry_t   q_mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           pop;
    logic           push;
    fetch_entry_t   head;

    assign imem_addr  = pc_q;
    assign inst_valid = (count != '0);
    assign head       = q_mem[rd_ptr];
    assign inst       = inst_valid ? head.word : 16'h0000;
    assign inst_pc    = inst_valid ? head.pc   : 32'h0000_0000;

`ifdef MIPS_FETCH_HALT_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

    // State register; reset always wins over redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the push/pop decisions and next PC; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pop     = inst_valid & inst_ready;
        push    = 1'b0;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = ST_FETCH;
            pc_d    = redirect_target;
        end else if (state_q == ST_FETCH && ((count != DEPTH_C) || pop)) begin
            push = 1'b1;
            pc_d = (pc_q == PC_LAST) ? 32'h0000_0000 : pc_q + 32'd1;
`ifdef MIPS_FETCH_HALT_EN
            // The halt word itself is still queued; only later fetches stop.
            if (imem_instruction == HALT_OPCODE) begin
                state_d = ST_HALT;
            end
`endif
        end
    end

    // Program counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Queue pointers and occupancy; a redirect drops everything, including a same-cycle pop.
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are don't-care while their slot is not counted.
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= '{pc: pc_q, word: imem_instruction};
        end
    end

endmodule

// File: tb/tb_mips_fetch_controller.sv
module tb_mips_fetch_controller;

    localparam int unsigned MEM_WORDS = 16;
    localparam int unsigned DEPTH     = 2;
    localparam logic [31:0] PC_RESET  = 32'd0;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;
`ifdef MIPS_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [15:0] imem_instruction;
    logic        inst_valid;
    logic [15:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halted;

    logic [15:0] mem [MEM_WORDS];

    // Reference model: PC, a queue of {pc, word}, and a halted flag
    logic [31:0] m_pc;
    logic [47:0] m_q [$];
    bit          m_halted;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign imem_instruction = (imem_addr < 32'(MEM_WORDS)) ? mem[imem_addr[3:0]] : 16'h0000;

    mips_fetch_controller #(
        .PC_RESET (PC_RESET),
        .MEM_WORDS(MEM_WORDS),
        .DEPTH    (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instruction(imem_instruction),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halted          (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit rdy, input bit rv, input logic [31:0] tgt);
        bit          pop;
        bit          push;
        logic [15:0] w;
        if (rst) begin
            m_pc     = PC_RESET;
            m_q.delete();
            m_halted = 1'b0;
            return;
        end
        pop = (m_q.size() != 0) && rdy;
        if (rv) begin
            m_q.delete();
            m_pc     = tgt;
            m_halted = 1'b0;
            return;
        end
        push = !m_halted && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            w = mem[m_pc[3:0]];
            m_q.push_back({m_pc, w});
            if (HALT_EN && w == HALT_WORD) m_halted = 1'b1;
            m_pc = (m_pc + 32'd1) % 32'(MEM_WORDS);
        end
    endtask

    task automatic compare_all();
        logic        ev;
        logic [15:0] ei;
        logic [31:0] ep;
        ev = (m_q.size() != 0);
        ei = ev ? m_q[0][15:0]  : 16'h0;
        ep = ev ? m_q[0][47:16] : 32'h0;
        chk("imem_addr",  imem_addr,         m_pc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
        chk("inst",       {16'b0, inst},     {16'b0, ei});
        chk("inst_pc",    inst_pc,           ep);
        chk("halted",     {31'b0, halted},   {31'b0, m_halted});
    endtask

    // One clock: apply inputs, advance model on the edge, compare on the falling edge
    task automatic step(input bit rst, input bit rdy, input bit rv, input logic [31:0] tgt);
        reset           = rst;
        inst_ready      = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(posedge clock);
        model_update(rst, rdy, rv, tgt);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        m_pc = PC_RESET; m_halted = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 16'h0100 + 16'(i);
        @(negedge clock);

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_addr",   imem_addr, 32'd0);
        chk("rst_valid",  {31'b0, inst_valid}, 32'd0);
        chk("rst_inst",   {16'b0, inst}, 32'd0);
        chk("rst_pc",     inst_pc, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);

        // Streaming at full rate, across the wrap
        for (int n = 1; n <= 17; n++) begin
            step(0, 1, 0, 0);
            if (n == 1) begin
                chk("first_inst", {16'b0, inst}, 32'h0100);
                chk("first_pc",   inst_pc, 32'd0);
            end
            if (n == 2) chk("second_inst", {16'b0, inst}, 32'h0101);
            if (n == 16) chk("last_pc", inst_pc, 32'd15);
            if (n == 17) begin
                chk("wrap_pc",   inst_pc, 32'd0);
                chk("wrap_inst", {16'b0, inst}, 32'h0100);
            end
        end

        // Stall with ready low, then drain with full queue in steady state
        step(1, 0, 0, 0);
        for (int n = 0; n < 5; n++) step(0, 0, 0, 0);
        chk("stall_addr", imem_addr, 32'd2);
        chk("stall_head", inst_pc, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, 0, 0);
            chk("full_head",  inst_pc, 32'(k));
            chk("full_addr",  imem_addr, 32'(k + 2));
            chk("full_valid", {31'b0, inst_valid}, 32'd1);
        end

        // Redirect while queue holds pc 3,4
        step(1, 0, 0, 0);
        for (int n = 0; n < 4; n++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("pre_redir_head", inst_pc, 32'd3);
        step(0, 0, 1, 9);
        chk("redir_bubble", {31'b0, inst_valid}, 32'd0);
        chk("redir_addr",   imem_addr, 32'd9);
        step(0, 1, 0, 0);
        chk("redir_pc",   inst_pc, 32'd9);
        chk("redir_inst", {16'b0, inst}, 32'h0109);

        // Reset beats a same-cycle redirect
        step(0, 1, 0, 0);
        step(1, 1, 1, 7);
        chk("rst_redir_addr",  imem_addr, PC_RESET);
        chk("rst_redir_valid", {31'b0, inst_valid}, 32'd0);

        // Halt opcode at address 5
        mem[5] = HALT_WORD;
        step(1, 0, 0, 0);
        for (int n = 0; n < 10; n++) step(0, 1, 0, 0);
        if (HALT_EN) begin
            chk("halt_flag",  {31'b0, halted}, 32'd1);
            chk("halt_addr",  imem_addr, 32'd6);
            chk("halt_valid", {31'b0, inst_valid}, 32'd0);
        end else begin
            chk("nohalt_flag", {31'b0, halted}, 32'd0);
            chk("nohalt_addr", imem_addr, 32'd10);
        end
        step(0, 1, 1, 0);
        chk("unhalt_flag", {31'b0, halted}, 32'd0);
        chk("unhalt_addr", imem_addr, 32'd0);
        step(0, 1, 0, 0);
        chk("refetch_pc", inst_pc, 32'd0);

        // Randomized traffic against the model
        step(1, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ((n % 200) == 0) begin
                for (int i = 0; i < MEM_WORDS; i++)
                    mem[i] = ($urandom_range(0, 7) == 0) ? HALT_WORD : 16'($urandom);
            end
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0,
                 32'($urandom_range(0, MEM_WORDS - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
